// File: rtl/freelist_reader_pkg.sv
// Shared RCU definitions used by the free-list read front end.
// Holds default widths and the rename request encoding.
package freelist_reader_pkg;

    localparam int DEF_PREG_WIDTH      = 6;
    localparam int DEF_FIFO_SIZE       = 32;
    localparam int DEF_FIFO_SIZE_WIDTH = 5;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_ONE  = 2'b01;
    localparam logic [1:0] REQ_TWO  = 2'b11;

endpackage

// File: rtl/freelist_hold_buf.sv
// Two-entry packed prefetch register for free physical-register IDs.
// Consumed entries shift out at index 0; popped words fill the free tail.
module freelist_hold_buf #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   cons,
    input  logic [1:0]   pop,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] buf0,
    output logic [W-1:0] buf1,
    output logic [1:0]   bcnt
);

    logic [1:0] r;

    assign r = bcnt - cons;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
            bcnt <= '0;
        end else begin
            case (r)
                2'd0: begin
                    if (pop != 2'd0) buf0 <= d0;
                    if (pop == 2'd2) buf1 <= d1;
                end
                2'd1: begin
                    // the survivor is buf1 only when one of two was taken
                    if (cons != 2'd0) buf0 <= buf1;
                    if (pop != 2'd0) buf1 <= d0;
                end
                default: ;
            endcase
            bcnt <= r + pop;
        end
    end

endmodule

// File: rtl/freelist_reader.sv
// Free-list read front end: prefetches up to two pregs per cycle and
// grants rename requests atomically from the registered buffer.
module freelist_reader
    import freelist_reader_pkg::*;
#(
    parameter int PREG_WIDTH      = DEF_PREG_WIDTH,
    parameter int FIFO_SIZE       = DEF_FIFO_SIZE,
    parameter int FIFO_SIZE_WIDTH = DEF_FIFO_SIZE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_first_i,
    input  logic                     req_second_i,
    output logic                     alloc_gnt_o,
    output logic [PREG_WIDTH-1:0]    alloc_preg_first_o,
    output logic [PREG_WIDTH-1:0]    alloc_preg_second_o,
    output logic [1:0]               alloc_avail_o,
    input  logic [PREG_WIDTH-1:0]    fifo_rdata_first_i,
    input  logic [PREG_WIDTH-1:0]    fifo_rdata_second_i,
    input  logic [FIFO_SIZE_WIDTH:0] fifo_num_i,
    output logic                     fifo_rd_first_en_o,
    output logic                     fifo_rd_second_en_o
);

    localparam int NW = FIFO_SIZE_WIDTH + 1;

    logic [1:0] req;
    logic [1:0] bcnt;
    logic [1:0] c;
    logic [1:0] r;
    logic [1:0] n;
    logic [1:0] p;

    assign req = {req_second_i, req_first_i};

    always_comb begin
        c = 2'd0;
        if (!rst) begin
            unique case (1'b1)
                (req == REQ_ONE && bcnt != 2'd0): c = 2'd1;
                (req == REQ_TWO && bcnt == 2'd2): c = 2'd2;
                default:                          c = 2'd0;
            endcase
        end
    end

    // fifo_num_i < n implies it is 0 or 1, so its low bits are exact
    always_comb begin
        r = bcnt - c;
        n = 2'd2 - r;
        p = 2'd0;
        if (!rst) begin
            if (fifo_num_i >= NW'(n)) p = n;
            else                      p = fifo_num_i[1:0];
        end
    end

    freelist_hold_buf #(
        .W (PREG_WIDTH)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .cons (c),
        .pop  (p),
        .d0   (fifo_rdata_first_i),
        .d1   (fifo_rdata_second_i),
        .buf0 (alloc_preg_first_o),
        .buf1 (alloc_preg_second_o),
        .bcnt (bcnt)
    );

    assign alloc_gnt_o         = (c != 2'd0);
    assign alloc_avail_o       = {bcnt == 2'd2, bcnt != 2'd0};
    assign fifo_rd_first_en_o  = (p != 2'd0);
    assign fifo_rd_second_en_o = (p == 2'd2);

    a_req_legal: assert property (
        @(posedge clk) disable iff (rst) !(req_second_i && !req_first_i)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) NW'(p) <= fifo_num_i
    );

endmodule

// File: doc/freelist_reader.md
Name: freelist_reader

Overview:
- Read-side front end for the dual-port free-list FIFO in the RCU.
- Pops up to two free physical-register IDs per cycle from the FIFO head and holds them in a 2-entry registered prefetch buffer.
- Serves allocation requests from the rename stage with an atomic 1-or-2 grant.
- Removes the FIFO's combinational head read and occupancy check from the rename critical path.

Parameters:
- PREG_WIDTH, 6, width of a physical register ID; equals the FIFO data width.
- FIFO_SIZE, 32, depth of the free-list FIFO.
- FIFO_SIZE_WIDTH, 5, log2(FIFO_SIZE).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req_first_i  input  1  rename requests one preg (slot 0).
- req_second_i  input  1  rename requests a second preg (slot 1); legal only with req_first_i.
- alloc_gnt_o  output  1  request granted this cycle; buffer entries consumed at next edge.
- alloc_preg_first_o  output  PREG_WIDTH  preg for slot 0 (buffer entry 0).
- alloc_preg_second_o  output  PREG_WIDTH  preg for slot 1 (buffer entry 1).
- alloc_avail_o  output  2  {entry1 valid, entry0 valid}; registered.
- fifo_rdata_first_i  input  PREG_WIDTH  FIFO head data.
- fifo_rdata_second_i  input  PREG_WIDTH  FIFO head+1 data.
- fifo_num_i  input  FIFO_SIZE_WIDTH+1  FIFO occupancy; combinational from FIFO pointers only.
- fifo_rd_first_en_o  output  1  pop FIFO head.
- fifo_rd_second_en_o  output  1  pop FIFO head+1; asserted only together with fifo_rd_first_en_o.

Behaviour:
- State: buf0, buf1 (PREG_WIDTH each) and bcnt (0..2). Entries are always packed; entry1 is valid only if entry0 is valid.
- Reset: bcnt=0, buf0=buf1=0, alloc_avail_o=00, alloc_gnt_o=0, FIFO read enables 0. The FIFO shares rst, so prefetched contents dropped at reset stay consistent.
- Consume count c, combinational:
  - req=01 and bcnt>=1: c=1.
  - req=11 and bcnt==2: c=2.
  - Otherwise c=0.
  - Grants are atomic; a 2-request with only 1 entry is a full stall, never partial.
  - req=10 is illegal: c=0 and an assertion fires.
- alloc_gnt_o = (c!=0). alloc_preg_first_o = buf0 and alloc_preg_second_o = buf1, driven at all times from registers.
- Refill, combinational in the same cycle:
  - Remaining entries r = bcnt - c.
  - Needed entries n = 2 - r.
  - Pops p = min(n, fifo_num_i).
  - p=1 asserts first_en only. p=2 asserts both.
- Next state:
  - Remaining entries shift to the lowest index (r=1 after c=1 moves buf1 to buf0).
  - Popped data fills the next free entries in order: fifo_rdata_first_i, then fifo_rdata_second_i.
  - bcnt <= r + p.
- Latency: a preg written into an empty FIFO at edge N is counted in fifo_num_i during cycle N+1, popped at edge N+1, and visible on alloc_avail_o in cycle N+2.
- Throughput: sustains 2 grants/cycle when fifo_num_i>=2 every cycle.
- No combinational path from req_*_i to alloc_avail_o. The req -> fifo_rd_en path is allowed because fifo_num_i does not depend on the read enables.
- Boundary conditions:
  - fifo_num_i=0: no pops. Buffer drains by grants only.
  - fifo_num_i=1 with n=2: pop 1.
  - Never pop more than fifo_num_i, so the FIFO never underflows.
  - FIFO wrap-around is handled entirely inside the FIFO. This block sees only data and count.
  - Grant and refill in the same cycle are normal operation; both take effect at one edge.

Decomposition:
- Shared RCU package holds:
  - PREG_WIDTH default.
  - Free-list FIFO_SIZE and FIFO_SIZE_WIDTH.
  - Request-encoding localparams REQ_NONE=2'b00, REQ_ONE=2'b01, REQ_TWO=2'b11.
- The single natural sub-module is freelist_hold_buf: 2-entry packed shift/fill register with inputs consume count, pop count and two data words, and outputs entries and bcnt. The grant and pop arithmetic stays in freelist_reader.

Test Plan:
- Reset, then preload FIFO with 7,8,9 (fifo_num=3), no requests:
  - Cycle 1: pops 2 (both enables).
  - Next cycle: alloc_avail=11, buf0=7, buf1=8, no further pop.
- Buffer {7,8}, fifo_num=1 (head 9), req=11:
  - alloc_gnt=1, grants 7 and 8, first_en only.
  - Next cycle: alloc_avail=01, buf0=9.
- Buffer {9} only, fifo_num=0, req=11:
  - alloc_gnt=0, no pop, state unchanged.
  - Then req=01: gnt=1 with preg 9, alloc_avail becomes 00.
- Steady stream, fifo_num>=2 each cycle, req=11 for 8 cycles:
  - 16 pregs granted in FIFO order, no gaps, both enables high every cycle.
- Write 5 into empty FIFO at edge N:
  - alloc_avail[0]=1 with buf0=5 in cycle N+2, not earlier.
- rst asserted mid-stream with buffer {3,4}:
  - Next cycle alloc_avail=00, read enables 0, gnt=0 even with req=11.
